imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 20, instruction word width.
REQ-002 The module SHALL have parameter MEM_SIZE, default 256, instruction memory depth in words.
REQ-003 The module SHALL have parameter ADDR_WIDTH, default 8, which SHALL equal $clog2(MEM_SIZE).
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  one-cycle request to begin a load session.
REQ-007 Port byte_valid  input  1  byte_data holds a valid byte.
REQ-008 Port byte_data  input  8  incoming program byte.
REQ-009 Port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port mem_we  output  1  instruction-memory write strobe.
REQ-011 Port mem_addr  output  ADDR_WIDTH  write address.
REQ-012 Port mem_wdata  output  DATA_WIDTH  assembled instruction word.
REQ-013 Port busy  output  1  session in progress.
REQ-014 Port done  output  1  last session completed without error.
REQ-015 Port error  output  1  last session aborted.
REQ-016 Port cpu_hold  output  1  processor held in reset while high.

Function
REQ-017 A byte SHALL be accepted only on a cycle with byte_valid=1 and byte_ready=1.
REQ-018 byte_ready SHALL be high only in states LEN_LO, LEN_HI, B0, B1, B2, and SHALL not depend combinationally on byte_valid.
REQ-019 The FSM SHALL have states IDLE, LEN_LO, LEN_HI, B0, B1, B2, WRITE, DONE, ERR.
REQ-020 start in IDLE, DONE or ERR SHALL move to LEN_LO, clear done, error and the address counter, and set busy; start in any other state SHALL be ignored.
REQ-021 The stream format SHALL be: word count N as 16 bits little-endian (LEN_LO, LEN_HI), then 3 bytes per word little-endian (B0=bits 7:0, B1=15:8, B2=19:16 in its low nibble).
REQ-022 After LEN_HI, N=0 SHALL go to DONE, N>MEM_SIZE SHALL go to ERR, and otherwise SHALL go to B0.
REQ-023 An accepted B2 byte with nonzero upper nibble SHALL go to ERR with no memory write.
REQ-024 An accepted valid B2 byte SHALL go to WRITE; WRITE SHALL last exactly one cycle with mem_we=1, mem_addr=current address, and mem_wdata=assembled word.
REQ-025 After WRITE the address SHALL increment by 1; when words written equals N the FSM SHALL go to DONE, otherwise to B0.
REQ-026 The address counter SHALL never wrap; the N<=MEM_SIZE check SHALL guarantee this.
REQ-027 In DONE, done SHALL be 1, busy 0 and cpu_hold 0.
REQ-028 In ERR, error SHALL be 1, busy 0 and cpu_hold 1.
REQ-029 mem_we SHALL be 0 in every state other than WRITE.
REQ-030 mem_wdata and mem_addr SHALL hold their last values when mem_we=0.
REQ-031 Byte-to-write latency SHALL be one cycle after B2 acceptance.
REQ-032 Peak throughput SHALL be one word per 4 cycles.

Reset
REQ-033 rst SHALL asynchronously force IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0 and cpu_hold=1, including mid-session.
REQ-034 After a mid-session reset, a new start SHALL be required, and words written before the reset SHALL not be rewritten by the loader.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the DATA_WIDTH/MEM_SIZE defaults and the byte-per-word constant (3).
REQ-036 The design SHALL be a single module with no sub-modules; the word assembler SHALL be inline shift/merge registers.

Verification
REQ-037 Reset, then start, then bytes 02 00 | 34 12 05 | FF FF 0F with byte_valid always 1 -> writes addr0=0x51234 and addr1=0xFFFFF, each a one-cycle mem_we; done=1, cpu_hold=0.
REQ-038 Same stream with byte_valid toggled 1/0 every cycle -> identical writes; no byte is accepted while byte_valid=0.
REQ-039 Length bytes 01 01 (N=257) -> ERR after LEN_HI with no mem_we; error=1, cpu_hold=1.
REQ-040 N=1 and B2 byte 0x1A -> ERR with no write; a following start and valid stream -> clean DONE with error cleared.
REQ-041 rst asserted after one of three words -> all outputs at reset values in the same cycle; start raised while busy -> ignored.
REQ-042 N=256 with word i = i -> last write at mem_addr=0xFF with data 0x000FF, then DONE, and no address wrap.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - default instruction word width and memory depth
//   - number of stream bytes that make up one instruction word
//   - loader FSM state encoding
package imem_loader_pkg;

  localparam int DEF_DATA_WIDTH = 20;
  localparam int DEF_MEM_SIZE   = 256;
  localparam int BYTES_PER_WORD = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (16-bit little-endian word count N,
// then three little-endian bytes per word) and writes the assembled words
// into instruction memory at consecutive addresses starting from 0.
// The processor is held in reset (cpu_hold) until a session completes
// cleanly.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   start            one-cycle request to begin a session (IDLE/DONE/ERR only)
//   byte_valid/data  incoming byte; accepted when byte_valid & byte_ready
//   byte_ready       loader can take a byte this cycle (state-decoded only)
//   mem_we/addr/wdata  instruction-memory write port, one-cycle strobe
//   busy/done/error  session status
//   cpu_hold         processor reset request
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_SIZE   = DEF_MEM_SIZE,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  state_t r_state;
  state_t w_next;

  logic [15:0]           r_len;
  logic [7:0]            r_b0;
  logic [7:0]            r_b1;
  // One bit wider than the address so N == MEM_SIZE words can be counted.
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [15:0] w_len;
  logic        w_b2_bad;
  logic        w_last_word;

  // Full word count as seen while the high length byte is on the bus.
  assign w_len       = {byte_data, r_len[7:0]};
  assign w_b2_bad    = |byte_data[7:4];
  assign w_last_word = (int'(r_cnt) + 1) == int'(r_len);

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and status outputs, all decoded from the current state so
  // byte_ready never depends on byte_valid.
  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          // Rejecting N > MEM_SIZE here is what keeps the address from wrapping.
          if (w_len == 16'd0)                w_next = S_DONE;
          else if (int'(w_len) > MEM_SIZE)   w_next = S_ERR;
          else                               w_next = S_B0;
        end
      end
      S_B0: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) w_next = S_B1;
      end
      S_B1: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) w_next = S_B2;
      end
      S_B2: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) w_next = w_b2_bad ? S_ERR : S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        w_next = w_last_word ? S_DONE : S_B0;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) w_next = S_LEN_LO;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) w_next = S_LEN_LO;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Word assembly and write-port registers. The write port is only loaded
  // on the B2 acceptance edge, so mem_addr/mem_wdata stay stable between
  // strobes while the next word is being collected in r_b0/r_b1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len      <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) r_cnt <= '0;
        end
        S_LEN_LO: begin
          if (byte_valid) r_len[7:0] <= byte_data;
        end
        S_LEN_HI: begin
          if (byte_valid) r_len <= w_len;
        end
        S_B0: begin
          if (byte_valid) r_b0 <= byte_data;
        end
        S_B1: begin
          if (byte_valid) r_b1 <= byte_data;
        end
        S_B2: begin
          if (byte_valid && !w_b2_bad) begin
            r_wdata    <= DATA_WIDTH'({byte_data[3:0], r_b1, r_b0});
            r_mem_addr <= r_cnt[ADDR_WIDTH-1:0];
          end
        end
        S_WRITE: begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [19:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  imem_loader #(
    .DATA_WIDTH(20),
    .MEM_SIZE  (256),
    .ADDR_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_hold  (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stream under test and the reference model's view of it.
  logic [7:0] stim[$];
  int         exp_addr[$];
  int         exp_data[$];
  bit         we_at[0:1023];
  bit         m_done;
  bit         m_err;
  int         m_consumed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_mem_we"},     mem_we,     0);
    check({tag, "_mem_addr"},   mem_addr,   0);
    check({tag, "_mem_wdata"},  mem_wdata,  0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
    check({tag, "_error"},      error,      0);
    check({tag, "_cpu_hold"},   cpu_hold,   1);
  endtask

  task automatic push_len(input int n);
    stim.push_back(8'(n % 256));
    stim.push_back(8'(n / 256));
  endtask

  task automatic push_word(input int w);
    stim.push_back(8'(w % 256));
    stim.push_back(8'((w / 256) % 256));
    stim.push_back(8'((w / 65536) % 16));
  endtask

  // Parse the stream by the format rules: what gets written, where the
  // session ends, and how many bytes the loader should take.
  task automatic build_model();
    int n;
    int base;
    int b0, b1, b2;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < 1024; i++) we_at[i] = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    n = int'(stim[0]) + 256 * int'(stim[1]);
    m_consumed = 2;
    if (n == 0) begin
      m_done = 1'b1;
    end else if (n > DEF_MEM_SIZE) begin
      m_err = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        base = 2 + BYTES_PER_WORD * k;
        b0 = int'(stim[base]);
        b1 = int'(stim[base + 1]);
        b2 = int'(stim[base + 2]);
        m_consumed = base + 3;
        if (b2 >= 16) begin
          m_err = 1'b1;
          break;
        end
        exp_addr.push_back(k);
        exp_data.push_back(b0 + 256 * b1 + 65536 * b2);
        we_at[base + 2] = 1'b1;
      end
      if (!m_err) m_done = 1'b1;
    end
  endtask

  // vmode: 0 = byte_valid always 1, 1 = toggled every cycle, 2 = random.
  task automatic run_session(input string tag, input int vmode, input bit poke_start);
    int  idx;
    int  cyc;
    int  wr;
    bit  exp_we;
    bit  fin;
    bit  tog;
    bit  v;
    idx = 0; cyc = 0; wr = 0; exp_we = 1'b0; fin = 1'b0; tog = 1'b1;
    build_model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_busy_on_start"}, busy,  1);
    check({tag, "_done_cleared"},  done,  0);
    check({tag, "_error_cleared"}, error, 0);
    while (!fin && cyc < 4000) begin
      start = 1'b0;
      check({tag, "_we"}, mem_we, exp_we);
      if (mem_we && exp_we) begin
        check({tag, "_addr"},  mem_addr,  exp_addr[wr]);
        check({tag, "_wdata"}, mem_wdata, exp_data[wr]);
        wr++;
      end
      if (done || error) begin
        fin = 1'b1;
        byte_valid = 1'b0;
      end else begin
        case (vmode)
          0:       v = 1'b1;
          1:       v = tog;
          default: v = 1'($urandom_range(0, 1));
        endcase
        tog = ~tog;
        byte_valid = v && (idx < stim.size());
        byte_data  = (idx < stim.size()) ? stim[idx] : 8'($urandom);
        if (poke_start && busy && $urandom_range(0, 5) == 0) start = 1'b1;
        exp_we = 1'b0;
        if (byte_valid && byte_ready) begin
          exp_we = we_at[idx];
          idx++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    check({tag, "_finished"},   fin, 1);
    check({tag, "_writes"},     wr,  exp_addr.size());
    check({tag, "_consumed"},   idx, m_consumed);
    check({tag, "_done"},       done,     m_done);
    check({tag, "_error"},      error,    m_err);
    check({tag, "_busy_end"},   busy,     0);
    check({tag, "_cpu_hold"},   cpu_hold, m_done ? 0 : 1);
    if (exp_addr.size() > 0) begin
      check({tag, "_addr_hold"},  mem_addr,  exp_addr[exp_addr.size() - 1]);
      check({tag, "_wdata_hold"}, mem_wdata, exp_data[exp_data.size() - 1]);
    end
  endtask

  task automatic random_stream(input bit allow_bad);
    int n;
    stim.delete();
    n = $urandom_range(0, 7);
    push_len(n);
    for (int k = 0; k < n; k++) begin
      stim.push_back(8'($urandom));
      stim.push_back(8'($urandom));
      if (allow_bad && $urandom_range(0, 9) == 0)
        stim.push_back(8'($urandom_range(16, 255)));
      else
        stim.push_back(8'($urandom_range(0, 15)));
    end
    for (int k = 0; k < 3; k++) stim.push_back(8'($urandom));
  endtask

  task automatic mid_session_reset();
    int idx;
    int cyc;
    bit seen;
    stim.delete();
    push_len(3);
    push_word(20'h0ABCD);
    push_word(20'h12345);
    push_word(20'h6789A);
    idx = 0; cyc = 0; seen = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!seen && cyc < 50) begin
      if (mem_we) seen = 1'b1;
      byte_valid = 1'b1;
      byte_data  = stim[idx];
      // A start pulse during the session must not restart it.
      start = (cyc == 3);
      if (byte_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("rst_first_write_seen", seen, 1);
    check("rst_write_addr", mem_addr, 0);
    check("rst_write_data", mem_wdata, 20'h0ABCD);
    check("rst_busy_before", busy, 1);
    byte_data = stim[idx];
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom_range(0, 15));
      @(negedge clk);
      check("rst_no_ready", byte_ready, 0);
      check("rst_no_write", mem_we, 0);
      check("rst_stays_idle", busy, 0);
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    // Two-word stream, byte_valid held high then toggled.
    stim.delete();
    stim = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h05, 8'hFF, 8'hFF, 8'h0F};
    run_session("two_words", 0, 1'b0);
    run_session("two_words_toggle", 1, 1'b0);

    // N = 257 exceeds the memory.
    stim.delete();
    stim = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h03};
    run_session("too_long", 0, 1'b0);

    // Bad B2 nibble, then a clean session afterwards.
    stim.delete();
    stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h1A};
    run_session("bad_b2", 2, 1'b0);
    stim.delete();
    push_len(3);
    push_word(20'h00001);
    push_word(20'hF0F0F);
    push_word(20'h80000);
    run_session("after_err", 2, 1'b0);

    // Zero-length session.
    stim.delete();
    push_len(0);
    run_session("empty", 0, 1'b0);

    mid_session_reset();
    stim.delete();
    push_len(2);
    push_word(20'h13579);
    push_word(20'h2468A);
    run_session("after_rst", 0, 1'b0);

    // Full memory, word i = i.
    stim.delete();
    push_len(256);
    for (int i = 0; i < 256; i++) push_word(i);
    run_session("full_mem", 0, 1'b0);

    // Random streams with random valid patterns and ignored start pulses.
    for (int t = 0; t < 12; t++) begin
      random_stream(1'b1);
      run_session("random", 2, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
